// File: rtl/text_lcd_pkg.sv
// text_lcd_pkg: shared types and constants for the text LCD arbiter and its helpers
package text_lcd_pkg;
  localparam int LCD_LINE_W = 128;
  localparam logic [LCD_LINE_W-1:0] LCD_BLANK_LINE = {16{8'h20}};
  typedef enum logic [1:0] {BG, LOAD, HOLD} state_t;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running 1 ms tick generator
// Ports: clk, rst_n (async, active low), tick (one-cycle pulse every CLK_HZ/1000 cycles)
module ms_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int DIV = CLK_HZ / 1000;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [CW-1:0] r_cnt;
  assign tick = (r_cnt == CW'(DIV - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/text_lcd_arbiter.sv
// text_lcd_arbiter: shares a 16x2 text LCD between a live background source and prioritised one-shot messages
// Ports: clk, rst_n (async, active low); req/req_line1/req_line2 per-source post pulse and text;
//        line1/line2 text to the LCD controller; grant capture pulse; owner shown source; busy message shown
module text_lcd_arbiter import text_lcd_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int CLK_HZ  = 50_000_000,
  parameter int HOLD_MS = 2000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*LCD_LINE_W-1:0] req_line1,
  input  logic [N_REQ*LCD_LINE_W-1:0] req_line2,
  output logic [LCD_LINE_W-1:0]       line1,
  output logic [LCD_LINE_W-1:0]       line2,
  output logic [N_REQ-1:0]            grant,
  output logic [$clog2(N_REQ)-1:0]    owner,
  output logic                        busy
);
  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(HOLD_MS);
  state_t           r_state, w_next;
  logic [N_REQ-1:0] r_pend;
  logic [HW-1:0]    r_hold;
  logic [OW-1:0]    w_sel;
  logic             w_tick, w_any, w_pre, w_exp;
  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (.clk(clk), .rst_n(rst_n), .tick(w_tick));
  always_comb begin
    w_sel = '0;
    for (int i = 1; i < N_REQ; i++) if (r_pend[i]) w_sel = OW'(i);
  end
  assign w_any = |r_pend;
  // sel == owner counts as preemption so a repost refreshes the hold
  assign w_pre = w_any && (w_sel >= owner);
  assign w_exp = w_tick && (r_hold == HW'(HOLD_MS - 1));
  always_comb
    w_next = r_state == BG   ? (w_any ? LOAD : BG) :
             r_state == LOAD ? HOLD :
             (w_pre || w_exp) ? (w_any ? LOAD : BG) : HOLD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= BG;
      r_pend  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      // a post arriving on its own grant edge stays pending and is served again
      r_pend  <= (r_state == LOAD ? r_pend & ~(N_REQ'(1) << w_sel) : r_pend) | {req[N_REQ-1:1], 1'b0};
      r_hold  <= r_state == LOAD ? '0 : (r_state == HOLD && w_tick) ? r_hold + 1'b1 : r_hold;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      line1 <= LCD_BLANK_LINE;
      line2 <= LCD_BLANK_LINE;
      grant <= '0;
      owner <= '0;
      busy  <= 1'b0;
    end else if (r_state == LOAD) begin
      line1 <= req_line1[w_sel*LCD_LINE_W +: LCD_LINE_W];
      line2 <= req_line2[w_sel*LCD_LINE_W +: LCD_LINE_W];
      grant <= N_REQ'(1) << w_sel;
      owner <= w_sel;
      busy  <= 1'b1;
    end else begin
      grant <= '0;
      // background follows live, and is picked up on the same edge a hold expires
      if (r_state == BG || w_next == BG) begin
        line1 <= req_line1[LCD_LINE_W-1:0];
        line2 <= req_line2[LCD_LINE_W-1:0];
        owner <= '0;
        busy  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_text_lcd_arbiter.sv
// tb_text_lcd_arbiter: self-checking bench with directed table, corner sequences and a random model comparison
`timescale 1ns/1ps
module tb_text_lcd_arbiter;
  localparam int N = 4;
  localparam int CLK_HZ = 10_000;
  localparam int HOLD_MS = 5;
  localparam int DIV = CLK_HZ / 1000;
  localparam logic [127:0] BLANK = {16{8'h20}};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*128-1:0] req_line1, req_line2;
  logic [127:0] line1, line2;
  logic [N-1:0] grant;
  logic [1:0] owner;
  logic busy;
  logic [127:0] txt1[N];
  logic [127:0] txt2[N];
  int n_vec = 0;
  int n_err = 0;
  text_lcd_arbiter #(.N_REQ(N), .CLK_HZ(CLK_HZ), .HOLD_MS(HOLD_MS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_line1(req_line1), .req_line2(req_line2),
    .line1(line1), .line2(line2), .grant(grant), .owner(owner), .busy(busy)
  );
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < N; i++) begin
      req_line1[i*128 +: 128] = txt1[i];
      req_line2[i*128 +: 128] = txt2[i];
    end
  function automatic logic [127:0] s2l(string s);
    logic [127:0] r;
    r = {16{8'h20}};
    for (int k = 0; k < 16 && k < s.len(); k++) r[127-8*k -: 8] = s[k];
    return r;
  endfunction
  function automatic logic [127:0] rnd_line();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'($urandom_range(32'h41, 32'h5a));
    return r;
  endfunction
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Reference model: source 0 shown live; a pending message is loaded one cycle after it is
  // noticed; a newer message of equal or higher index cuts in; otherwise the hold ends on the
  // HOLD_MS-th millisecond tick after loading and the next queued message (or background) follows.
  logic [127:0] m_l1, m_l2;
  logic [N-1:0] m_grant;
  int m_owner, m_edges, m_ms;
  bit m_busy, m_loading;
  bit m_pend[N];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_l1 = BLANK; m_l2 = BLANK; m_grant = '0; m_owner = 0; m_busy = 0;
      m_loading = 0; m_edges = 0; m_ms = 0;
      for (int i = 0; i < N; i++) m_pend[i] = 0;
    end else begin : step
      int hp;
      bit any, tk;
      hp = 0;
      for (int i = 1; i < N; i++) if (m_pend[i]) hp = i;
      any = hp != 0;
      tk = (m_edges % DIV) == DIV - 1;
      m_edges++;
      m_grant = '0;
      if (m_loading) begin
        m_loading = 0; m_l1 = txt1[hp]; m_l2 = txt2[hp]; m_grant[hp] = 1'b1;
        m_owner = hp; m_busy = 1; m_pend[hp] = 0; m_ms = 0;
      end else if (m_busy) begin
        if (any && hp >= m_owner) m_loading = 1;
        else if (tk) begin
          if (m_ms == HOLD_MS - 1) begin
            if (any) m_loading = 1;
            else begin m_busy = 0; m_owner = 0; m_l1 = txt1[0]; m_l2 = txt2[0]; end
          end else m_ms++;
        end
      end else begin
        m_l1 = txt1[0]; m_l2 = txt2[0];
        if (any) m_loading = 1;
      end
      for (int i = 1; i < N; i++) if (req[i]) m_pend[i] = 1;
    end
  end
  typedef struct { logic [3:0] rq; int wt; logic [1:0] own; logic bsy; } vec_t;
  vec_t tbl[13];
  task automatic pulse(logic [3:0] m);
    req = m;
    @(negedge clk);
    req = '0;
  endtask
  task automatic wait_idle(output int n);
    n = 1;
    while (busy && n < 200) begin @(negedge clk); n++; end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bit seen;
    for (int i = 0; i < N; i++) begin txt1[i] = BLANK; txt2[i] = BLANK; end
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_line1", line1, BLANK);
    chk("rst_line2", line2, BLANK);
    chk("rst_owner", 128'(owner), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant), 128'(0));
    txt1[0] = s2l("SCORE 0000"); txt2[0] = s2l("BACKGROUND");
    rst_n = 1'b1;
    @(negedge clk);
    chk("bg_line1", line1, s2l("SCORE 0000"));
    chk("bg_line2", line2, s2l("BACKGROUND"));
    chk("bg_busy", 128'(busy), 128'(0));
    txt1[2] = s2l("GAME OVER"); txt2[2] = s2l("PRESS START");
    pulse(4'b0100);
    chk("msg_grant_k1", 128'(grant), 128'(0));
    @(negedge clk);
    chk("msg_grant_k2", 128'(grant), 128'(0));
    chk("msg_line1_pre", line1, s2l("SCORE 0000"));
    @(negedge clk);
    chk("msg_grant", 128'(grant), 128'(4'b0100));
    chk("msg_line1", line1, s2l("GAME OVER"));
    chk("msg_line2", line2, s2l("PRESS START"));
    chk("msg_owner", 128'(owner), 128'(2));
    chk("msg_busy", 128'(busy), 128'(1));
    txt1[2] = s2l("CHANGED");
    @(negedge clk);
    chk("msg_grant_off", 128'(grant), 128'(0));
    chk("msg_snapshot", line1, s2l("GAME OVER"));
    wait_idle(n);
    chk("msg_hold_len", 128'(n >= (HOLD_MS-1)*DIV && n <= HOLD_MS*DIV + 1), 128'(1));
    chk("msg_back_bg", line1, s2l("SCORE 0000"));
    chk("msg_back_owner", 128'(owner), 128'(0));
    txt1[1] = s2l("MSG ONE"); txt1[2] = s2l("MSG TWO"); txt1[3] = s2l("MSG THREE");
    tbl[0]  = '{4'b0010, 2,  2'd1, 1'b1};
    tbl[1]  = '{4'b1000, 10, 2'd3, 1'b1};
    tbl[2]  = '{4'b0100, 2,  2'd3, 1'b1};
    tbl[3]  = '{4'b0000, 50, 2'd2, 1'b1};
    tbl[4]  = '{4'b0000, 50, 2'd0, 1'b0};
    tbl[5]  = '{4'b1000, 2,  2'd3, 1'b1};
    tbl[6]  = '{4'b0010, 20, 2'd3, 1'b1};
    tbl[7]  = '{4'b0000, 40, 2'd1, 1'b1};
    tbl[8]  = '{4'b0000, 60, 2'd0, 1'b0};
    tbl[9]  = '{4'b1110, 2,  2'd3, 1'b1};
    tbl[10] = '{4'b0000, 55, 2'd2, 1'b1};
    tbl[11] = '{4'b0000, 55, 2'd1, 1'b1};
    tbl[12] = '{4'b0000, 60, 2'd0, 1'b0};
    for (int v = 0; v < 13; v++) begin
      pulse(tbl[v].rq);
      repeat (tbl[v].wt) @(negedge clk);
      chk($sformatf("tbl%0d_owner", v), 128'(owner), 128'(tbl[v].own));
      chk($sformatf("tbl%0d_busy", v), 128'(busy), 128'(tbl[v].bsy));
      chk($sformatf("tbl%0d_line1", v), line1, txt1[tbl[v].own]);
    end
    txt1[2] = s2l("REFRESH A");
    pulse(4'b0100);
    repeat (2) @(negedge clk);
    chk("ref_first", line1, s2l("REFRESH A"));
    repeat (38) @(negedge clk);
    txt1[2] = s2l("REFRESH B");
    pulse(4'b0100);
    repeat (2) @(negedge clk);
    chk("ref_line1", line1, s2l("REFRESH B"));
    chk("ref_grant", 128'(grant), 128'(4'b0100));
    wait_idle(n);
    chk("ref_hold_len", 128'(n >= (HOLD_MS-1)*DIV && n <= HOLD_MS*DIV + 1), 128'(1));
    pulse(4'b1000);
    repeat (2) @(negedge clk);
    pulse(4'b0010);
    repeat (5) @(negedge clk);
    chk("mid_busy_pre", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_line1", line1, BLANK);
    chk("mid_rst_line2", line2, BLANK);
    chk("mid_rst_owner", 128'(owner), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (120) begin @(negedge clk); seen |= busy; end
    chk("mid_no_stale", 128'(seen), 128'(0));
    chk("mid_bg_line1", line1, s2l("SCORE 0000"));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_line1", line1, m_l1);
      chk("rnd_line2", line2, m_l2);
      chk("rnd_grant", 128'(grant), 128'(m_grant));
      chk("rnd_owner", 128'(owner), 128'(m_owner));
      chk("rnd_busy", 128'(busy), 128'(m_busy));
      for (int i = 0; i < N; i++) begin
        req[i] = $urandom_range(0, 99) < 3;
        if (!m_pend[i] && $urandom_range(0, 19) == 0) begin
          txt1[i] = rnd_line();
          txt2[i] = rnd_line();
        end
      end
    end
    req = '0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/text_lcd_arbiter.md
# text_lcd_arbiter

Shares the 16x2 text LCD between up to N_REQ message sources and drives the `line1`/`line2` inputs of the existing HD44780 text LCD controller.
- Source 0 is the background screen and is shown live whenever no other source holds the display.
- Sources 1..N_REQ-1 post one-shot messages. Each granted message is snapshotted and held for HOLD_MS milliseconds.
- Higher-index sources preempt lower ones.

## Interface
- `N_REQ`, default 4: number of sources, including background source 0; range 2..8.
- `CLK_HZ`, default 50_000_000: clock frequency, used for the 1 ms tick.
- `HOLD_MS`, default 2000: display hold time per granted message, in ms; must be ≥ 2.
- `clk`  in  1: system clock, 50 MHz. This is the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  N_REQ: one-cycle post pulse per source; `req[0]` is ignored.
- `req_line1`  in  N_REQ*128: per-source line-1 text. Source i occupies bits [i*128 +: 128]; the leftmost character is in the MSB byte.
- `req_line2`  in  N_REQ*128: per-source line-2 text, same packing as `req_line1`.
- `line1`  out  128: line-1 text to the LCD controller.
- `line2`  out  128: line-2 text to the LCD controller.
- `grant`  out  N_REQ: one-cycle pulse marking the cycle in which source i's text was captured.
- `owner`  out  $clog2(N_REQ): index of the source currently displayed.
- `busy`  out  1: high while a message (not the background) is displayed.

## Operation
- **Reset values:** `line1` = `line2` = 16×8'h20 (spaces); `grant` = 0; `owner` = 0; `busy` = 0. All pending bits, the tick prescaler and the hold counter are cleared. State = BG.
- **Pending register:** `pend[i]` (i ≥ 1) is set at any edge where `req[i]` = 1. It is cleared only at the LOAD edge that grants source i. A repeated `req` while already pending has no further effect.
- **Selection:** `sel` = highest index i with `pend[i]` = 1.
- **States:**
  - BG:
    - `line1`/`line2` ← `req_line1[0]`/`req_line2[0]` every cycle (1-cycle registered follow).
    - `owner` = 0, `busy` = 0.
    - If any `pend` bit is set → LOAD.
  - LOAD (one cycle):
    - `line1`/`line2` ← text of source `sel`.
    - `grant[sel]` ← 1 for one cycle.
    - `owner` ← `sel`; `pend[sel]` ← 0; hold counter ← 0; `busy` ← 1.
    - → HOLD.
  - HOLD:
    - Outputs frozen.
    - If any `pend[i]` with i ≥ `owner` → LOAD. This is preemption; i = `owner` acts as a refresh that restarts the hold.
    - Else, at a tick where hold count = HOLD_MS−1: if any `pend` bit is set → LOAD (the lower-priority queue), else → BG.
- **Snapshot rule:** requesters keep `req_line*` stable from `req` until their `grant` pulse. Text is sampled only at the LOAD edge.
- Lower-priority pending requests are never dropped. They wait and are served in descending index order as each hold expires.

## Timing
- **ms tick:** free-running prescaler counting 0..CLK_HZ/1000−1. `tick` is high for one cycle at the terminal count. The prescaler is never reset by the FSM.
- **Hold counter:** width $clog2(HOLD_MS). Increments on `tick` in HOLD and cleared in LOAD. Effective hold is HOLD_MS−1 to HOLD_MS ms.
- **Latency from BG:** `req[i]` sampled at edge k → `pend` set at k → LOAD entered at k+1 → at edge k+2 `line*` show the new text and `grant[i]` is high for the cycle after k+2.
- **Preemption latency from HOLD:** identical, 2 edges.
- **Simultaneous events:**
  - Expiry and preemption in the same cycle: preemption wins; the result is the same LOAD with the highest `sel`.
  - `req` from several sources in one cycle: all are latched; the highest is served first.
- **Reset asserted mid-HOLD:** immediate return to the reset values above; pending requests are lost.

## Structure
- **Package `text_lcd_pkg`:**
  - state enum (BG, LOAD, HOLD);
  - constant `LCD_BLANK_LINE` = {16{8'h20}};
  - `LCD_LINE_W` = 128.
- **Sub-module `ms_tick_gen`** (parameter CLK_HZ; ports `clk`, `rst_n`, `tick`): reusable by other timed blocks.
- The remainder (pending register, priority select, FSM, output registers) stays in one module.

## Test plan
- **Reset/background:** hold `rst_n` = 0 → `line1` = `line2` = 16 spaces, `owner` = 0. Release `rst_n`, set source 0 to "SCORE 0000" → `line1` matches 1 cycle later; `busy` = 0.
- **Single message:** pulse `req[2]` with "GAME OVER" → 2 edges later `line1` = "GAME OVER", `grant` = 4'b0100 for 1 cycle, `owner` = 2. Change source 2 text afterwards → display unchanged. After HOLD_MS (use HOLD_MS = 5, CLK_HZ = 10_000) → back to BG, `busy` = 0.
- **Preemption and queue:** `req[1]`, then `req[3]` mid-hold, then `req[2]` → display order 1, 3, 2. Source 1 is not re-shown; source 2 appears after source 3's hold expires.
- **No lower-priority preemption:** owner = 3, pulse `req[1]` → display stays 3 until expiry, then shows 1.
- **Refresh:** owner = 2, pulse `req[2]` at 4 ms with new text → new text within 2 edges; hold restarts, giving ~9 ms total.
- **Reset mid-operation:** assert `rst_n` during HOLD with `pend` nonzero → blank lines, BG state. After release, no stale message appears.
